uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving uart_clk cycles per bit; it must be even and in the range 8..64.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal values are 5..9.
REQ-003 SHALL have parameter PARITY, default 0, where 0 = none, 1 = odd and 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, with legal values 1 or 2.
REQ-005 uart_clk  in  1  sole clock; each cycle is one oversample tick.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 rxd  in  1  serial line, asynchronous to uart_clk, idle high.
REQ-008 rx_data  out  DATA_BITS  received word, LSB received first.
REQ-009 rx_valid  out  1  rx_data and the error flags hold an unconsumed word.
REQ-010 rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
REQ-011 rx_parity_err  out  1  parity mismatch for the held word; forced 0 when PARITY == 0.
REQ-012 rx_frame_err  out  1  at least one stop bit of the held word sampled low.
REQ-013 rx_overrun  out  1  sticky flag: a completed frame was dropped.
REQ-014 overrun_clr  in  1  single-cycle clear of rx_overrun.
REQ-015 rx_busy  out  1  state is not IDLE.

Function
REQ-016 SHALL pass rxd through a 2-flop synchronizer (rxd_s); both flops reset to 1.
REQ-017 SHALL arm start detection only after rxd_s has been sampled 1 at least once since reset.
REQ-018 SHALL use states IDLE, START, DATA, PAR, STOP, with tick counter tick_cnt (0..OVERSAMPLE-1) and bit counter bit_cnt.
REQ-019 IDLE->START occurs when armed and rxd_s is 0 in a cycle after it was 1; that cycle is t0, tick 0 of the start bit.
REQ-020 Each bit's value SHALL be the 2-of-3 majority of rxd_s at ticks M-1, M and M+1, where M = OVERSAMPLE/2; the decision is made at tick M+1.
REQ-021 START: a decision of 1 is a false start -> return to IDLE with no output and no flags changed.
REQ-022 Bit boundary: tick_cnt wraps from OVERSAMPLE-1 to 0, and the state/bit_cnt advance.
- Order: START -> DATA (DATA_BITS bits) -> PAR (only if PARITY != 0) -> STOP (STOP_BITS bits).
REQ-023 Parity SHALL be computed as XOR over the data bits and the parity bit: odd mode expects 1, even mode expects 0.
REQ-024 At the decision tick of the last stop bit, SHALL return to IDLE immediately (not at the end of the bit) so the next start edge is caught.
REQ-025 Frame-complete event occurs at that same decision tick.
- Word and flags are registered at the clock edge ending the tick.
- rx_valid is visible at t0 + (1+DATA_BITS+P+STOP_BITS-1)*OVERSAMPLE + M + 2, where P is 1 if parity is enabled, else 0.
REQ-026 rx_valid SHALL remain 1, and rx_data and the error flags SHALL remain stable, until a cycle with rx_ready == 1.
REQ-027 Acceptance with no completion in the same cycle SHALL clear rx_valid on the next edge.
REQ-028 Completion in the same cycle as acceptance loads the new word, keeps rx_valid at 1, and does not set rx_overrun.
REQ-029 Completion while rx_valid == 1 without acceptance drops the new word (old word retained) and sets rx_overrun.
REQ-030 Overrun set and overrun_clr in the same cycle: set wins.
REQ-031 Framing error does not suppress delivery; the word is delivered with rx_frame_err = 1.
REQ-032 A line held low SHALL not retrigger a new frame until rxd_s returns to 1.

Reset
REQ-033 While reset == 0:
- state = IDLE, tick_cnt = 0, bit_cnt = 0.
- rx_data = 0, rx_valid = 0, rx_parity_err = 0, rx_frame_err = 0, rx_overrun = 0, rx_busy = 0.
- start detection disarmed.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no partial word delivered; operation resumes per REQ-016/017 after reset release.

Verification
REQ-035 Defaults, rxd sends 0xA5 in 8N1 with rx_ready = 0 -> rx_valid rises at t0+154, rx_data = 0xA5, both error flags 0.
REQ-036 Glitch: rxd low for 5 ticks then high -> no rx_valid and state back to IDLE by t0+10; then 0x3C sent -> rx_data = 0x3C.
REQ-037 PARITY = 2, 0x07 sent with parity bit 0 -> rx_data = 0x07, rx_parity_err = 1.
- Same frame with correct parity bit 1 -> rx_parity_err = 0.
REQ-038 Stop bit forced low on 0x55 -> rx_data = 0x55, rx_frame_err = 1.
- Next frame 0x12 -> delivered cleanly.
REQ-039 Two frames 0x11 then 0x22 with rx_ready = 0 -> rx_data stays 0x11, rx_overrun = 1.
- Repeat with rx_ready pulsed exactly at the second completion cycle -> rx_data = 0x22, rx_valid stays 1, rx_overrun = 0.
REQ-040 Reset asserted at t0+60 of a frame, rxd held low through release -> no rx_valid until rxd returns high and a full new frame arrives.

Source files
------------

// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop sync, 3-tap majority vote, odd/even parity, 1-2 stops.
// Ports: uart_clk/reset, rxd in; rx_data/rx_valid/flags out, rx_ready, overrun_clr in.
module uart_rx_param #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 uart_clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 overrun_clr,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_ZERO = '0;
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MM1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_M    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_MP1  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    B_DLST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    B_SLST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           sync_q;
  logic [1:0]           fill_q;
  logic                 armed_q, prev_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 par_q, par_d;
  logic                 facc_q, facc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic rxd_s, start_det, decide, wrap, bit_v;
  logic done, done_ferr, perr_v, accept;

  assign rxd_s = sync_q[1];
  // Reset value of the sync chain must not arm the detector,
  // so only count a 1 once real line data has filled both flops.
  assign start_det = armed_q & prev_q & ~rxd_s;
  assign decide = (state_q != IDLE) && (tick_q == T_MP1);
  assign wrap = (tick_q == T_LAST);
  assign bit_v = (samp_q[0] & samp_q[1]) |
                 (samp_q[0] & rxd_s) |
                 (samp_q[1] & rxd_s);
  assign perr_v = (PARITY == 1) ? ~par_q :
                  (PARITY == 2) ?  par_q : 1'b0;
  assign accept = valid_q & rx_ready;

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
      samp_q  <= 2'b00;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      facc_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & rxd_s);
      prev_q  <= rxd_s;
      if (tick_q == T_MM1) samp_q[0] <= rxd_s;
      if (tick_q == T_M) samp_q[1] <= rxd_s;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      facc_q  <= facc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    par_d     = par_q;
    facc_d    = facc_q;
    done      = 1'b0;
    done_ferr = 1'b0;
    if (state_q != IDLE) begin
      tick_d = wrap ? T_ZERO : tick_q + T_ONE;
    end
    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          // Detection cycle is tick 0 of the start bit.
          state_d = START;
          tick_d  = T_ONE;
          bit_d   = 4'd0;
          par_d   = 1'b0;
          facc_d  = 1'b0;
        end
      end
      START: begin
        if (decide && bit_v) begin
          state_d = IDLE;
          tick_d  = T_ZERO;
        end else if (wrap) begin
          state_d = DATA;
          bit_d   = 4'd0;
        end
      end
      DATA: begin
        if (decide) begin
          sr_d  = {bit_v, sr_q[DATA_BITS-1:1]};
          par_d = par_q ^ bit_v;
        end
        if (wrap) begin
          if (bit_q == B_DLST) begin
            bit_d   = 4'd0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (decide) par_d = par_q ^ bit_v;
        if (wrap) begin
          state_d = STOP;
          bit_d   = 4'd0;
        end
      end
      STOP: begin
        if (decide) facc_d = facc_q | ~bit_v;
        if (decide && (bit_q == B_SLST)) begin
          // Leave early so a start edge right after the
          // stop decision is not missed.
          done      = 1'b1;
          done_ferr = facc_q | ~bit_v;
          state_d   = IDLE;
          tick_d    = T_ZERO;
          bit_d     = 4'd0;
        end else if (wrap) begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = T_ZERO;
        bit_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (done && (!valid_q || accept)) begin
      data_d  = sr_q;
      perr_d  = perr_v;
      ferr_d  = done_ferr;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) ovr_d = 1'b0;
    if (done && valid_q && !accept) ovr_d = 1'b1;
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default 8N1 instance and an even-parity instance.
// Scoreboard queues per instance; monitor pops on each accepted word.
module tb_uart_rx_param;

  logic       clk;
  logic       rst_n;
  logic       rxd0, rxd2;
  logic       rdy0, rdy2;
  logic       clr0, clr2;
  logic [7:0] d0, d2;
  logic       v0, v2, pe0, pe2, fe0, fe2, ov0, ov2, b0, b2;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  uart_rx_param u0 (
    .uart_clk(clk), .reset(rst_n), .rxd(rxd0),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .rx_parity_err(pe0), .rx_frame_err(fe0),
    .rx_overrun(ov0), .overrun_clr(clr0), .rx_busy(b0)
  );

  uart_rx_param #(.PARITY(2)) u2 (
    .uart_clk(clk), .reset(rst_n), .rxd(rxd2),
    .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2),
    .rx_parity_err(pe2), .rx_frame_err(fe2),
    .rx_overrun(ov2), .overrun_clr(clr2), .rx_busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rxd0 = b;
    else rxd2 = b;
  endtask

  task automatic send(input int sel, input logic [7:0] d,
                      input bit pen, input logic pb,
                      input logic sb);
    drive(sel, 1'b0);
    step(16);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      step(16);
    end
    if (pen) begin
      drive(sel, pb);
      step(16);
    end
    drive(sel, sb);
    step(16);
    drive(sel, 1'b1);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe,
                              input logic fe, input logic ov);
    exp_t e;
    e.d = d;
    e.pe = pe;
    e.fe = fe;
    e.ov = ov;
    return e;
  endfunction

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (v0 && rdy0) begin
      nchk++;
      if (q0.size() == 0) begin
        nerr++;
        $display("FAIL u0 unexpected word: got %0h want none", d0);
      end else begin
        e = q0.pop_front();
        if (d0 !== e.d || pe0 !== e.pe || fe0 !== e.fe || ov0 !== e.ov) begin
          nerr++;
          $display("FAIL u0 word: got d=%0h pe=%0b fe=%0b ov=%0b want d=%0h pe=%0b fe=%0b ov=%0b",
                   d0, pe0, fe0, ov0, e.d, e.pe, e.fe, e.ov);
        end
      end
    end
    if (v2 && rdy2) begin
      nchk++;
      if (q2.size() == 0) begin
        nerr++;
        $display("FAIL u2 unexpected word: got %0h want none", d2);
      end else begin
        e = q2.pop_front();
        if (d2 !== e.d || pe2 !== e.pe || fe2 !== e.fe || ov2 !== e.ov) begin
          nerr++;
          $display("FAIL u2 word: got d=%0h pe=%0b fe=%0b ov=%0b want d=%0h pe=%0b fe=%0b ov=%0b",
                   d2, pe2, fe2, ov2, e.d, e.pe, e.fe, e.ov);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rxd0 = 1'b1;
    rxd2 = 1'b1;
    rdy0 = 1'b1;
    rdy2 = 1'b1;
    clr0 = 1'b0;
    clr2 = 1'b0;
    step(3);
    chk("rst valid0", 32'(v0), 32'd0);
    chk("rst data0", 32'(d0), 32'd0);
    chk("rst flags0", {28'd0, pe0, fe0, ov0, b0}, 32'd0);
    chk("rst valid2", 32'(v2), 32'd0);
    chk("rst flags2", {28'd0, pe2, fe2, ov2, b2}, 32'd0);
    rst_n = 1'b1;
    step(10);

    // 0xA5 8N1, valid must rise at t0+154
    rdy0 = 1'b0;
    q0.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    fork
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        step(155);
        chk("A5 valid early", 32'(v0), 32'd0);
        step(1);
        chk("A5 valid t0+154", 32'(v0), 32'd1);
        chk("A5 data", 32'(d0), 32'hA5);
        chk("A5 flags", {30'd0, pe0, fe0}, 32'd0);
      end
    join
    step(10);
    chk("A5 held", 32'(d0), 32'hA5);
    rdy0 = 1'b1;
    step(5);

    // 5-tick glitch is a false start
    fork
      begin
        rxd0 = 1'b0;
        step(5);
        rxd0 = 1'b1;
      end
      begin
        step(5);
        chk("glitch busy", 32'(b0), 32'd1);
        step(7);
        chk("glitch idle t0+10", 32'(b0), 32'd0);
      end
    join
    step(20);
    q0.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(10);

    // even parity on u2: 0x07 has three ones
    q2.push_back(mk(8'h07, 1'b1, 1'b0, 1'b0));
    send(2, 8'h07, 1'b1, 1'b0, 1'b1);
    step(10);
    q2.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
    send(2, 8'h07, 1'b1, 1'b1, 1'b1);
    step(10);

    // framing error, then clean frame
    q0.push_back(mk(8'h55, 1'b0, 1'b1, 1'b0));
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    step(10);
    rxd0 = 1'b1;
    step(20);
    q0.push_back(mk(8'h12, 1'b0, 1'b0, 1'b0));
    send(0, 8'h12, 1'b0, 1'b0, 1'b1);
    step(10);

    // overrun: second word dropped
    rdy0 = 1'b0;
    q0.push_back(mk(8'h11, 1'b0, 1'b0, 1'b1));
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    step(5);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    step(5);
    chk("ovr set", 32'(ov0), 32'd1);
    chk("ovr keeps old", 32'(d0), 32'h11);
    chk("ovr valid", 32'(v0), 32'd1);
    rdy0 = 1'b1;
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    step(2);
    chk("ovr cleared", 32'(ov0), 32'd0);
    chk("ovr drained", 32'(v0), 32'd0);

    // accept in the same cycle as the next completion
    rdy0 = 1'b0;
    q0.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    step(5);
    q0.push_back(mk(8'h22, 1'b0, 1'b0, 1'b0));
    fork
      send(0, 8'h22, 1'b0, 1'b0, 1'b1);
      begin
        step(155);
        rdy0 = 1'b1;
        step(1);
        rdy0 = 1'b0;
        chk("same-cycle valid", 32'(v0), 32'd1);
        chk("same-cycle data", 32'(d0), 32'h22);
        chk("same-cycle ovr", 32'(ov0), 32'd0);
      end
    join
    step(5);
    rdy0 = 1'b1;
    step(5);

    // reset mid-frame with line held low
    rxd0 = 1'b0;
    step(62);
    rst_n = 1'b0;
    step(3);
    chk("midrst valid", 32'(v0), 32'd0);
    chk("midrst busy", 32'(b0), 32'd0);
    rst_n = 1'b1;
    step(100);
    chk("low hold busy", 32'(b0), 32'd0);
    chk("low hold valid", 32'(v0), 32'd0);
    rxd0 = 1'b1;
    step(20);
    q0.push_back(mk(8'h6B, 1'b0, 1'b0, 1'b0));
    send(0, 8'h6B, 1'b0, 1'b0, 1'b1);
    step(10);

    for (int i = 0; i < 200 && (q0.size() != 0 || q2.size() != 0); i++)
      step(1);
    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q2 drained", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
